operand_entry_fsm: RTL and testbench

//   Upstream operand-capture stage of the calculator's subtract path. Takes two
//   4-bit operands from the board switches, one per press of the ENTER button.

---
 rtl/operand_entry_fsm.sv | 147 ++++++++++++++
 tb/tb_operand_entry_fsm.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_entry_fsm.sv
// Operand-capture stage for the subtract path: conditions the ENTER and CLEAR
// buttons, then latches two switch operands into registered a/b for the subtractor.
module operand_entry_fsm #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned DB_CYCLES = 250000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_enter,
  input  logic             btn_clear,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             op_valid,
  output logic [1:0]       state_led
);

  localparam int unsigned NBTN      = 2;
  localparam int unsigned BTN_ENTER = 0;
  localparam int unsigned BTN_CLEAR = 1;
  localparam int unsigned CNT_W     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    DONE   = 2'b10,
    UNUSED = 2'b11
  } state_e;

  logic [NBTN-1:0]            raw_c;
  logic [NBTN-1:0]            sync1_q, sync1_d;
  logic [NBTN-1:0]            sync2_q, sync2_d;
  logic [NBTN-1:0]            db_q, db_d;
  logic [NBTN-1:0]            db_dly_q, db_dly_d;
  logic [NBTN-1:0]            pulse_q, pulse_d;
  logic [NBTN-1:0][CNT_W-1:0] cnt_q, cnt_d;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             op_valid_q, op_valid_d;

  logic             enter_c;
  logic             clear_c;

  assign raw_c = {btn_clear, btn_enter};

  // Button conditioning: synchronise, debounce, then one-clock pulse on each debounced rise.
  always_comb begin
    sync1_d  = raw_c;
    sync2_d  = sync1_q;
    db_d     = db_q;
    db_dly_d = db_q;
    pulse_d  = '0;
    cnt_d    = '0;
    for (int i = 0; i < NBTN; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = CNT_W'(cnt_q[i] + 1'b1);
        end
      end
      pulse_d[i] = db_q[i] & ~db_dly_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      db_dly_q <= '0;
      pulse_q  <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      db_q     <= db_d;
      db_dly_q <= db_dly_d;
      pulse_q  <= pulse_d;
      cnt_q    <= cnt_d;
    end
  end

  assign enter_c = pulse_q[BTN_ENTER];
  assign clear_c = pulse_q[BTN_CLEAR];

  // Entry sequencing; a simultaneous clear overrides any enter.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_valid_d = op_valid_q;
    if (clear_c) begin
      state_d    = LOAD_A;
      a_d        = '0;
      b_d        = '0;
      op_valid_d = 1'b0;
    end else begin
      case (state_q)
        LOAD_A: begin
          if (enter_c) begin
            a_d     = sw;
            state_d = LOAD_B;
          end
        end
        LOAD_B: begin
          if (enter_c) begin
            b_d        = sw;
            op_valid_d = 1'b1;
            state_d    = DONE;
          end
        end
        DONE: begin
          if (enter_c) begin
            a_d        = sw;
            op_valid_d = 1'b0;
            state_d    = LOAD_B;
          end
        end
        default: state_d = LOAD_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD_A;
      a_q        <= '0;
      b_q        <= '0;
      op_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_valid_q <= op_valid_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign op_valid  = op_valid_q;
  assign state_led = state_q;

endmodule

// File: tb/tb_operand_entry_fsm.sv
// Scoreboard bench for operand_entry_fsm: every expected output change is queued
// by the stimulus and matched by a monitor that watches the outputs.
module tb_operand_entry_fsm;

  localparam int unsigned WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] sw;
  logic             btn_enter;
  logic             btn_clear;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             op_valid;
  logic [1:0]       state_led;

  operand_entry_fsm #(.WIDTH(WIDTH), .DB_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw        (sw),
    .btn_enter (btn_enter),
    .btn_clear (btn_clear),
    .a         (a),
    .b         (b),
    .op_valid  (op_valid),
    .state_led (state_led)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       st;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             v;
  } snap_t;

  snap_t exp_q[$];
  snap_t cur, last, e;
  int    n_checks = 0;
  int    n_fail   = 0;
  bit    mon_en   = 0;
  bit    primed   = 0;
  int    snap_req = 0;
  int    snap_done = 0;
  bit    end_req  = 0;
  bit    end_done = 0;

  // Monitor: each output change consumes one expected entry; snapshot requests compare now.
  always @(negedge clk) begin
    if (mon_en) begin
      cur = {state_led, a, b, op_valid};
      if (!primed) begin
        last   = cur;
        primed = 1;
      end
      if (cur != last) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change: got st=%b a=%h b=%h v=%b, required no change (st=%b a=%h b=%h v=%b)",
                   cur.st, cur.a, cur.b, cur.v, last.st, last.a, last.b, last.v);
        end else begin
          e = exp_q.pop_front();
          if (cur != e) begin
            n_fail++;
            $display("FAIL output_change: got st=%b a=%h b=%h v=%b, required st=%b a=%h b=%h v=%b",
                     cur.st, cur.a, cur.b, cur.v, e.st, e.a, e.b, e.v);
          end
        end
        last = cur;
      end
      if (snap_done != snap_req) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL snapshot: no expected entry queued, got st=%b a=%h b=%h v=%b",
                   cur.st, cur.a, cur.b, cur.v);
        end else begin
          e = exp_q.pop_front();
          if (cur != e) begin
            n_fail++;
            $display("FAIL snapshot: got st=%b a=%h b=%h v=%b, required st=%b a=%h b=%h v=%b",
                     cur.st, cur.a, cur.b, cur.v, e.st, e.a, e.b, e.v);
          end
        end
        snap_done = snap_req;
      end
      if (end_req && !end_done) begin
        n_checks++;
        if (exp_q.size() != 0) begin
          n_fail++;
          $display("FAIL drain: %0d expected changes never seen, required 0", exp_q.size());
        end
        end_done = 1;
      end
    end
  end

  function automatic snap_t mk(input logic [1:0] st, input logic [3:0] av,
                               input logic [3:0] bv, input logic v);
    mk = {st, av, bv, v};
  endfunction

  task automatic expect_change(input snap_t s);
    exp_q.push_back(s);
  endtask

  task automatic snapshot(input snap_t s);
    exp_q.push_back(s);
    snap_req++;
    repeat (2) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
  endtask

  task automatic press_enter(input logic [3:0] v);
    @(negedge clk);
    sw        = v;
    btn_enter = 1'b1;
    repeat (8) @(negedge clk);
    btn_enter = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic press_clear();
    @(negedge clk);
    btn_clear = 1'b1;
    repeat (8) @(negedge clk);
    btn_clear = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    sw        = '0;
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1;

    // Reset state
    snapshot(mk(2'b00, 4'h0, 4'h0, 1'b0));

    // Glitches shorter than the debounce window are ignored
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      btn_enter = 1'b1;
      repeat (n) @(negedge clk);
      btn_enter = 1'b0;
      repeat (10) @(negedge clk);
    end
    snapshot(mk(2'b00, 4'h0, 4'h0, 1'b0));

    // Basic pair 9, 3
    expect_change(mk(2'b01, 4'h9, 4'h0, 1'b0));
    press_enter(4'h9);
    expect_change(mk(2'b10, 4'h9, 4'h3, 1'b1));
    press_enter(4'h3);
    drain();

    // Held ENTER with toggling switches: single capture on the pulse edge
    expect_change(mk(2'b00, 4'h0, 4'h0, 1'b0));
    press_clear();
    expect_change(mk(2'b01, 4'h6, 4'h0, 1'b0));
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 0) btn_enter = 1'b1;
      sw = 4'(i * 3 + 1);
    end
    btn_enter = 1'b0;
    repeat (12) @(negedge clk);
    drain();

    // New pair started from DONE keeps old b until overwritten
    expect_change(mk(2'b00, 4'h0, 4'h0, 1'b0));
    press_clear();
    expect_change(mk(2'b01, 4'h2, 4'h0, 1'b0));
    press_enter(4'h2);
    expect_change(mk(2'b10, 4'h2, 4'h5, 1'b1));
    press_enter(4'h5);
    expect_change(mk(2'b01, 4'hF, 4'h5, 1'b0));
    press_enter(4'hF);
    expect_change(mk(2'b10, 4'hF, 4'h1, 1'b1));
    press_enter(4'h1);
    drain();

    // Clear and enter aligned in LOAD_B: clear wins, enter dropped
    expect_change(mk(2'b01, 4'h7, 4'h1, 1'b0));
    press_enter(4'h7);
    expect_change(mk(2'b00, 4'h0, 4'h0, 1'b0));
    @(negedge clk);
    sw        = 4'hA;
    btn_enter = 1'b1;
    btn_clear = 1'b1;
    repeat (8) @(negedge clk);
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    repeat (12) @(negedge clk);
    drain();
    snapshot(mk(2'b00, 4'h0, 4'h0, 1'b0));

    // Reset mid-debounce in DONE, button released early: no pulse
    expect_change(mk(2'b01, 4'h4, 4'h0, 1'b0));
    press_enter(4'h4);
    expect_change(mk(2'b10, 4'h4, 4'h8, 1'b1));
    press_enter(4'h8);
    drain();
    expect_change(mk(2'b00, 4'h0, 4'h0, 1'b0));
    @(negedge clk);
    btn_enter = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    btn_enter = 1'b0;
    repeat (20) @(negedge clk);
    drain();
    snapshot(mk(2'b00, 4'h0, 4'h0, 1'b0));

    // Button held across reset release yields exactly one capture
    expect_change(mk(2'b01, 4'hC, 4'h0, 1'b0));
    @(negedge clk);
    sw        = 4'hC;
    btn_enter = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    btn_enter = 1'b0;
    repeat (12) @(negedge clk);
    drain();

    end_req = 1;
    for (int i = 0; i < 50 && !end_done; i++) @(negedge clk);
    if (!end_done) begin
      n_checks++;
      n_fail++;
      $display("FAIL end_check: monitor did not respond, required response within 50 clocks");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
